// File: rtl/event_pulse_multi.sv
// event_pulse_multi: multi-channel synchronised edge pulser with timestamped event FIFO
module event_pulse_multi #(
  parameter  int NUM_CH      = 8,
  parameter  int SYNC_STAGES = 2,
  parameter  int TS_WIDTH    = 32,
  parameter  int FIFO_DEPTH  = 16,
  localparam int AW          = $clog2(FIFO_DEPTH),
  localparam int DW          = TS_WIDTH + 2*NUM_CH + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   in,
  input  logic [2*NUM_CH-1:0] mode,
  input  logic                enable,
  output logic [NUM_CH-1:0]   rising_edge,
  output logic [NUM_CH-1:0]   falling_edge,
  output logic [NUM_CH-1:0]   both_edges,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic [DW-1:0]       ev_data,
  output logic [AW:0]         ev_level,
  output logic [15:0]         drop_count
);
  logic [NUM_CH-1:0]   sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0]   s, p, hit;
  logic [TS_WIDTH-1:0] ts_cnt;
  logic [DW-1:0]       mem [FIFO_DEPTH];
  logic [AW:0]         wr_ptr, rd_ptr;
  logic                drop_pending, rec, full, wr_en, rd_en;

  // synchroniser chain plus the one-cycle delayed copy used for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      p <= '0;
    end else begin
      sync_q[0] <= in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      p <= s;
    end
  end

  assign s            = sync_q[SYNC_STAGES-1];
  assign rising_edge  = ~p & s;
  assign falling_edge = p & ~s;
  assign both_edges   = rising_edge | falling_edge;

  // per-channel qualification of edges against the record mode
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_CH; i++)
      hit[i] = (mode[2*i] & rising_edge[i]) | (mode[2*i+1] & falling_edge[i]);
  end

  assign rec      = enable & (|hit);
  assign ev_level = wr_ptr - rd_ptr;
  assign ev_valid = wr_ptr != rd_ptr;
  assign full     = ev_level == (AW+1)'(FIFO_DEPTH);
  assign wr_en    = rec & ~full;
  assign rd_en    = ev_valid & ev_ready;
  assign ev_data  = ev_valid ? mem[rd_ptr[AW-1:0]] : '0;

  // timestamp, FIFO pointers and overflow bookkeeping; full is judged before any same-cycle read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      drop_pending <= 1'b0;
      drop_count   <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (rec) drop_pending <= full;
      if (rec && full && !(&drop_count)) drop_count <= drop_count + 1'b1;
    end
  end

  // record storage; contents need no reset since the output is masked while empty
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {drop_pending, ts_cnt, s, hit};
  end
endmodule

// File: tb/tb_event_pulse_multi.sv
// tb_event_pulse_multi: table, directed and randomized checks of event_pulse_multi against a history-based model
module tb_event_pulse_multi;
  localparam int N  = 4;
  localparam int S  = 2;
  localparam int TW = 8;
  localparam int D  = 4;
  localparam int DW = TW + 2*N + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] in = '0;
  logic [2*N-1:0] mode = '0;
  logic enable = 1'b0;
  logic ev_ready = 1'b0;
  logic [N-1:0] rising_edge, falling_edge, both_edges;
  logic ev_valid;
  logic [DW-1:0] ev_data;
  logic [$clog2(D):0] ev_level;
  logic [15:0] drop_count;

  event_pulse_multi #(.NUM_CH(N), .SYNC_STAGES(S), .TS_WIDTH(TW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .mode(mode), .enable(enable),
    .rising_edge(rising_edge), .falling_edge(falling_edge), .both_edges(both_edges),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data),
    .ev_level(ev_level), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int m_drop = 0;
  int pushes = 0;
  logic m_pend = 1'b0;
  logic [N-1:0] hist [int];
  logic [DW-1:0] q [$];

  typedef struct {
    logic [N-1:0] in;
    logic         en;
    logic         rdy;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] hit;
    logic         v;
    int           lvl;
  } vec_t;
  vec_t tbl [15];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endfunction

  // input value applied in cycle c (zero before reset release)
  function automatic logic [N-1:0] h(input int c);
    return (c < 0 || !hist.exists(c)) ? '0 : hist[c];
  endfunction

  // check the current cycle's outputs, drive this cycle's inputs, advance model and clock
  task automatic cycle(input logic [N-1:0] i, input logic en, input logic rdy);
    logic [N-1:0] sv, pv, r, f, ht;
    logic full;
    sv = h(cyc - S);
    pv = h(cyc - S - 1);
    r = ~pv & sv;
    f = pv & ~sv;
    chk("rising_edge", 64'(rising_edge), 64'(r));
    chk("falling_edge", 64'(falling_edge), 64'(f));
    chk("both_edges", 64'(both_edges), 64'(r | f));
    chk("ev_valid", 64'(ev_valid), 64'(q.size() != 0));
    chk("ev_level", 64'(ev_level), 64'(q.size()));
    chk("ev_data", 64'(ev_data), q.size() != 0 ? 64'(q[0]) : 64'(0));
    chk("drop_count", 64'(drop_count), 64'(m_drop));
    in = i;
    enable = en;
    ev_ready = rdy;
    ht = '0;
    for (int k = 0; k < N; k++) ht[k] = (mode[2*k] & r[k]) | (mode[2*k+1] & f[k]);
    full = q.size() == D;
    if (rdy && q.size() != 0) void'(q.pop_front());
    if (en && ht != '0) begin
      if (full) begin
        m_pend = 1'b1;
        if (m_drop < 65535) m_drop++;
      end else begin
        q.push_back({m_pend, TW'(cyc), sv, ht});
        m_pend = 1'b0;
        pushes++;
      end
    end
    hist[cyc] = i;
    if (hist.exists(cyc - S - 2)) hist.delete(cyc - S - 2);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // asynchronous reset mid-cycle, immediate output check, release just after an edge
  task automatic do_reset(input logic [N-1:0] i);
    #2;
    rst_n = 1'b0;
    in = i;
    #1;
    chk("rst_rising", 64'(rising_edge), 64'(0));
    chk("rst_falling", 64'(falling_edge), 64'(0));
    chk("rst_both", 64'(both_edges), 64'(0));
    chk("rst_valid", 64'(ev_valid), 64'(0));
    chk("rst_level", 64'(ev_level), 64'(0));
    chk("rst_data", 64'(ev_data), 64'(0));
    chk("rst_drops", 64'(drop_count), 64'(0));
    q.delete();
    hist.delete();
    cyc = 0;
    m_drop = 0;
    m_pend = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] cur, nx;
    logic [DW-1:0] exp_rec;
    int start, budget;
    tbl[0]  = '{4'b0010, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0};
    tbl[1]  = '{4'b0010, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0};
    tbl[2]  = '{4'b0010, 1'b1, 1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b0, 0};
    tbl[3]  = '{4'b0101, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0};
    tbl[4]  = '{4'b0101, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0};
    tbl[5]  = '{4'b0101, 1'b1, 1'b0, 4'b0101, 4'b0010, 4'b0000, 1'b0, 0};
    tbl[6]  = '{4'b0101, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0011, 1'b1, 1};
    tbl[7]  = '{4'b0010, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0011, 1'b1, 1};
    tbl[8]  = '{4'b0010, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0011, 1'b1, 1};
    tbl[9]  = '{4'b0010, 1'b0, 1'b0, 4'b0010, 4'b0101, 4'b0011, 1'b1, 1};
    tbl[10] = '{4'b0101, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0011, 1'b1, 1};
    tbl[11] = '{4'b0101, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0011, 1'b1, 1};
    tbl[12] = '{4'b0101, 1'b0, 1'b0, 4'b0101, 4'b0010, 4'b0011, 1'b1, 1};
    tbl[13] = '{4'b0101, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0011, 1'b1, 1};
    tbl[14] = '{4'b0101, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0};

    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) cycle('0, 1'b0, 1'b0);

    // table: pulses, mode filtering, merged record, enable gating
    mode = 8'b00_00_10_01;
    for (int r = 0; r < 15; r++) begin
      chk("tbl_rise", 64'(rising_edge), 64'(tbl[r].rise));
      chk("tbl_fall", 64'(falling_edge), 64'(tbl[r].fall));
      chk("tbl_both", 64'(both_edges), 64'(tbl[r].rise | tbl[r].fall));
      chk("tbl_valid", 64'(ev_valid), 64'(tbl[r].v));
      chk("tbl_level", 64'(ev_level), 64'(tbl[r].lvl));
      chk("tbl_hit", 64'(ev_data[N-1:0]), 64'(tbl[r].hit));
      cycle(tbl[r].in, tbl[r].en, tbl[r].rdy);
    end

    // overflow: six events into a four-entry FIFO with no reader
    mode = 8'hFF;
    cur = in;
    for (int k = 0; k < 6; k++) begin
      cur[0] = ~cur[0];
      cycle(cur, 1'b1, 1'b0);
    end
    repeat (4) cycle(cur, 1'b1, 1'b0);
    chk("ovf_level", 64'(ev_level), 64'(4));
    chk("ovf_drops", 64'(drop_count), 64'(2));
    repeat (5) cycle(cur, 1'b1, 1'b1);
    chk("ovf_drained", 64'(ev_level), 64'(0));
    cur[3] = ~cur[3];
    cycle(cur, 1'b1, 1'b0);
    repeat (3) cycle(cur, 1'b1, 1'b0);
    chk("ovf_flag_valid", 64'(ev_valid), 64'(1));
    chk("ovf_flag_set", 64'(ev_data[DW-1]), 64'(1));
    cycle(cur, 1'b1, 1'b1);
    cur[3] = ~cur[3];
    cycle(cur, 1'b1, 1'b0);
    repeat (3) cycle(cur, 1'b1, 1'b0);
    chk("ovf_flag_clear", 64'(ev_data[DW-1]), 64'(0));

    // backpressure: head record held for five cycles
    exp_rec = q.size() != 0 ? q[0] : '0;
    repeat (5) begin
      chk("bp_valid", 64'(ev_valid), 64'(1));
      chk("bp_stable", 64'(ev_data), 64'(exp_rec));
      cycle(cur, 1'b1, 1'b0);
    end
    repeat (2) cycle(cur, 1'b1, 1'b1);

    // timestamp wrap: pulses in cycles 254 and 257
    do_reset('0);
    mode = 8'hFF;
    while (cyc < 252) cycle('0, 1'b1, 1'b0);
    repeat (3) cycle(4'b0001, 1'b1, 1'b0);
    while (cyc < 258) cycle('0, 1'b1, 1'b0);
    chk("wrap_level", 64'(ev_level), 64'(2));
    chk("wrap_ts_254", 64'(ev_data[DW-2 -: TW]), 64'(254));
    cycle('0, 1'b1, 1'b1);
    chk("wrap_ts_1", 64'(ev_data[DW-2 -: TW]), 64'(1));
    repeat (2) cycle('0, 1'b1, 1'b1);

    // reset with three records buffered and all inputs high
    cycle(4'b0001, 1'b1, 1'b0);
    cycle(4'b0011, 1'b1, 1'b0);
    cycle(4'b0111, 1'b1, 1'b0);
    repeat (3) cycle(4'b0111, 1'b1, 1'b0);
    chk("pre_reset_level", 64'(ev_level), 64'(3));
    do_reset(4'b1111);
    cycle(4'b1111, 1'b1, 1'b0);
    chk("post_reset_quiet", 64'(rising_edge), 64'(0));
    cycle(4'b1111, 1'b1, 1'b0);
    chk("post_reset_rise", 64'(rising_edge), 64'(4'b1111));
    repeat (3) cycle(4'b1111, 1'b1, 1'b1);

    // randomized burst against the model
    mode = 8'b11_10_01_11;
    start = pushes;
    budget = 0;
    while (pushes - start < 1000 && budget < 6000) begin
      nx = ($urandom % 2) != 0 ? N'($urandom) : in;
      cycle(nx, ($urandom % 8) != 0, ($urandom % 4) != 0);
      budget++;
    end
    chk("burst_records", 64'(pushes - start >= 1000), 64'(1));
    repeat (8) cycle(in, 1'b1, 1'b1);
    chk("burst_drained", 64'(ev_level), 64'(0));

    // drop counter saturation
    mode = 8'hFF;
    cur = in;
    repeat (65600) begin
      cur[0] = ~cur[0];
      cycle(cur, 1'b1, 1'b0);
    end
    repeat (3) cycle(cur, 1'b1, 1'b0);
    chk("drop_saturated", 64'(drop_count), 64'(16'hFFFF));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
